// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target endpoint: frame field widths,
// command opcodes and the frame-decoder state encoding.
package spi_pkg;

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAME_W = CMD_W + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned ERR_W   = 8;

  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;
  localparam logic [CMD_W-1:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_WAIT_CS
  } state_e;

  // Saturating increment for the abort counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// SPI pin and register-bus bundle for spi_target; slave = the endpoint,
// master = whatever drives the SPI pins and serves the register file.
interface spi_target_if;
  import spi_pkg::*;

  logic                spi_cs;
  logic                spi_sck;
  logic                spi_mosi;
  logic                spi_miso;
  logic [ADDR_W-1:0]   reg_addr;
  logic [DATA_W-1:0]   reg_wdata;
  logic                reg_we;
  logic                reg_re;
  logic [DATA_W-1:0]   reg_rdata;
  logic                frame_done;
  logic [ERR_W-1:0]    err_cnt;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, reg_rdata,
    output spi_miso, reg_addr, reg_wdata, reg_we, reg_re, frame_done, err_cnt
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, reg_rdata,
    input  spi_miso, reg_addr, reg_wdata, reg_we, reg_re, frame_done, err_cnt
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with registered
// single-cycle rise/fall pulses (pin-to-pulse latency STAGES+1 clk).
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Chain resets low so a pin already low after reset never looks like a fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: decodes 8b cmd / 24b addr / 32b data frames into register
// bus strobes and returns read data on MISO. Define SPI_TARGET_ERR_CNT_EN to count aborts.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_target_if.slave   bus
);

  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   w_start;
  logic                   w_shift;
  logic                   w_cmd_done;
  logic                   w_addr_done;
  logic                   w_data_done;
  logic                   w_tx_shift;

  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_rx;
  logic [DATA_W-1:0]      w_rx_next;
  logic [CMD_W-1:0]       r_cmd;
  logic [DATA_W-1:0]      r_tx;
  logic                   r_miso;
  logic [ADDR_W-1:0]      r_reg_addr;
  logic [DATA_W-1:0]      r_reg_wdata;
  logic                   r_reg_we;
  logic                   r_reg_re;
  logic                   r_re_d;
  logic                   r_frame_done;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (bus.spi_cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (bus.spi_sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // MOSI needs no edge detect; it is stable for half an SCK period around the sample.
  always_ff @(posedge clk) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_next = {r_rx[DATA_W-2:0], w_mosi};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Frame sequencing; cs_rise always wins over a coincident SCK edge.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_cmd_done   = 1'b0;
    w_addr_done  = 1'b0;
    w_data_done  = 1'b0;
    w_tx_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ST_CMD;
          w_start      = 1'b1;
        end
      end
      ST_CMD: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end else if (w_sck_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
            w_state_next = ST_ADDR;
            w_cmd_done   = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end else if (w_sck_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(CMD_W + ADDR_W - 1)) begin
            w_state_next = ST_DATA;
            w_addr_done  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_cs_rise) begin
          w_state_next = ST_IDLE;
        end else begin
          w_tx_shift = w_sck_rise;
          if (w_sck_fall) begin
            w_shift = 1'b1;
            if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
              w_state_next = ST_WAIT_CS;
              w_data_done  = 1'b1;
            end
          end
        end
      end
      ST_WAIT_CS: begin
        if (w_cs_rise) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_cmd        <= '0;
      r_tx         <= '0;
      r_miso       <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_reg_we     <= 1'b0;
      r_reg_re     <= 1'b0;
      r_re_d       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_reg_we     <= 1'b0;
      r_reg_re     <= 1'b0;
      r_frame_done <= 1'b0;
      r_re_d       <= r_reg_re;

      if (w_start) begin
        r_bit_cnt <= '0;
        r_rx      <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_rx      <= w_rx_next;
      end

      if (w_cmd_done) r_cmd <= w_rx_next[CMD_W-1:0];

      if (w_addr_done) begin
        r_reg_addr <= w_rx_next[ADDR_W-1:0];
        r_reg_re   <= (r_cmd == CMD_READ);
      end

      if (w_data_done) begin
        if (r_cmd == CMD_WRITE) begin
          r_reg_wdata <= w_rx_next;
          r_reg_we    <= 1'b1;
        end
        r_frame_done <= 1'b1;
      end

      // Read data lands one cycle after the reg_re pulse has been seen by the register file.
      if (w_start)         r_tx <= '0;
      else if (r_re_d)     r_tx <= bus.reg_rdata;
      else if (w_tx_shift) r_tx <= {r_tx[DATA_W-2:0], 1'b0};

      if (w_tx_shift)              r_miso <= r_tx[DATA_W-1];
      else if (r_state != ST_DATA) r_miso <= 1'b0;
    end
  end

  assign bus.spi_miso   = r_miso;
  assign bus.reg_addr   = r_reg_addr;
  assign bus.reg_wdata  = r_reg_wdata;
  assign bus.reg_we     = r_reg_we;
  assign bus.reg_re     = r_reg_re;
  assign bus.frame_done = r_frame_done;

`ifdef SPI_TARGET_ERR_CNT_EN
  logic             w_abort;
  logic [ERR_W-1:0] r_err_cnt;

  assign w_abort = w_cs_rise &&
                   ((r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA));

  always_ff @(posedge clk) begin
    if (rst)          r_err_cnt <= '0;
    else if (w_abort) r_err_cnt <= sat_inc(r_err_cnt);
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = ERR_W'(0);
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed frames plus randomized back-to-back
// traffic checked against a frame-level reference model.
module tb_spi_target;
  import spi_pkg::*;

  logic clk;
  logic rst;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          done_cnt = 0;
  int          we_nodone = 0;
  logic [31:0] mon_wdata;
  logic [23:0] mon_waddr;
  logic [23:0] mon_raddr;

  logic [31:0] rd_val;
  logic [63:0] miso_cap;
  logic [23:0] exp_addr;
  logic [31:0] exp_wdata;
  int          exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file side: rdata is valid only in the cycle after reg_re, junk otherwise.
  initial begin
    bus.reg_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.reg_re === 1'b1) begin
        #1 bus.reg_rdata = rd_val;
        @(posedge clk);
        #1 bus.reg_rdata = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we === 1'b1) begin
        we_cnt++;
        mon_wdata = bus.reg_wdata;
        mon_waddr = bus.reg_addr;
        if (bus.frame_done !== 1'b1) we_nodone++;
      end
      if (bus.reg_re === 1'b1) begin
        re_cnt++;
        mon_raddr = bus.reg_addr;
      end
      if (bus.frame_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master behaviour: MOSI driven at SCK rise, MISO sampled at SCK fall.
  task automatic send_bits(input logic [63:0] f, input int first, input int n, input int half);
    for (int i = first; i < first + n; i++) begin
      bus.spi_sck = 1'b1;
      if (i < 64) bus.spi_mosi = f[63-i];
      else        bus.spi_mosi = 1'($urandom);
      wait_clk(half);
      bus.spi_sck = 1'b0;
      if (i < 64) miso_cap = {miso_cap[62:0], bus.spi_miso};
      wait_clk(half);
    end
  endtask

  task automatic do_frame(input logic [63:0] f, input int nbits, input int half,
                          output int d_we, output int d_re, output int d_done);
    int we0, re0, dn0;
    we0 = we_cnt; re0 = re_cnt; dn0 = done_cnt;
    miso_cap = 64'h0;
    bus.spi_cs = 1'b0;
    wait_clk(half);
    send_bits(f, 0, nbits, half);
    bus.spi_cs   = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(2 * half + 8);
    d_we   = we_cnt - we0;
    d_re   = re_cnt - re0;
    d_done = done_cnt - dn0;
  endtask

  // Frame-level reference: what one cs window of nbits sampled bits must produce.
  task automatic model_frame(input logic [63:0] f, input int nbits,
                             output int e_we, output int e_re, output int e_done);
    logic [7:0] c;
    c = f[63:56];
    e_we = 0; e_re = 0; e_done = 0;
    if (nbits >= 32) begin
      exp_addr = f[55:32];
      if (c == 8'h03) e_re = 1;
    end
    if (nbits >= 64) begin
      e_done = 1;
      if (c == 8'h02) begin
        e_we      = 1;
        exp_wdata = f[31:0];
      end
    end else begin
`ifdef SPI_TARGET_ERR_CNT_EN
      if (exp_err < 255) exp_err++;
`endif
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
    wait_clk(5);
    exp_addr = 24'h0; exp_wdata = 32'h0; exp_err = 0;
    n_checks++;
    if ({bus.spi_miso, bus.reg_we, bus.reg_re, bus.frame_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000",
                         {bus.spi_miso, bus.reg_we, bus.reg_re, bus.frame_done});
    end
    n_checks++;
    if (bus.reg_addr !== 24'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 000000", bus.reg_addr);
    end
    n_checks++;
    if (bus.reg_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", bus.reg_wdata);
    end
    n_checks++;
    if (bus.err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_err: got %h expected 00", bus.err_cnt);
    end
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_write;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed;
    f = {8'h02, 24'h00_1234, 32'hDEAD_BEEF};
    do_frame(f, 64, 8, dw, dr, dd);
    model_frame(f, 64, ew, er, ed);
    n_checks++;
    if (dw !== 1) begin n_fail++; $display("FAIL write_we_count: got %0d expected 1", dw); end
    n_checks++;
    if (dr !== 0) begin n_fail++; $display("FAIL write_re_count: got %0d expected 0", dr); end
    n_checks++;
    if (dd !== 1) begin n_fail++; $display("FAIL write_done_count: got %0d expected 1", dd); end
    n_checks++;
    if (mon_waddr !== 24'h001234) begin
      n_fail++; $display("FAIL write_addr: got %h expected 001234", mon_waddr);
    end
    n_checks++;
    if (mon_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_wdata: got %h expected deadbeef", mon_wdata);
    end
    n_checks++;
    if (miso_cap !== 64'h0) begin
      n_fail++; $display("FAIL write_miso: got %h expected 0", miso_cap);
    end
    n_checks++;
    if (we_nodone !== 0) begin
      n_fail++; $display("FAIL write_we_done_align: got %0d expected 0", we_nodone);
    end
  endtask

  task automatic test_read;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed;
    rd_val = 32'hA5A5_0F0F;
    f = {8'h03, 24'h00_0010, 32'h0};
    do_frame(f, 64, 8, dw, dr, dd);
    model_frame(f, 64, ew, er, ed);
    n_checks++;
    if (miso_cap[31:0] !== 32'hA5A50F0F) begin
      n_fail++; $display("FAIL read_miso_data: got %h expected a5a50f0f", miso_cap[31:0]);
    end
    n_checks++;
    if (miso_cap[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL read_miso_header: got %h expected 0", miso_cap[63:32]);
    end
    n_checks++;
    if (dw !== 0) begin n_fail++; $display("FAIL read_we_count: got %0d expected 0", dw); end
    n_checks++;
    if (dr !== 1) begin n_fail++; $display("FAIL read_re_count: got %0d expected 1", dr); end
    n_checks++;
    if (mon_raddr !== 24'h000010) begin
      n_fail++; $display("FAIL read_addr: got %h expected 000010", mon_raddr);
    end
    n_checks++;
    if (dd !== 1) begin n_fail++; $display("FAIL read_done_count: got %0d expected 1", dd); end
  endtask

  task automatic test_unknown_cmd;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed;
    rd_val = 32'hFFFF_FFFF;
    f = {8'h7E, 24'h12_3456, 32'hCAFE_F00D};
    do_frame(f, 64, 7, dw, dr, dd);
    model_frame(f, 64, ew, er, ed);
    n_checks++;
    if ({dw, dr} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL unknown_strobes: got we=%0d re=%0d expected 0/0", dw, dr);
    end
    n_checks++;
    if (dd !== 1) begin n_fail++; $display("FAIL unknown_done: got %0d expected 1", dd); end
    n_checks++;
    if (miso_cap !== 64'h0) begin
      n_fail++; $display("FAIL unknown_miso: got %h expected 0", miso_cap);
    end
    n_checks++;
    if (bus.reg_wdata !== exp_wdata) begin
      n_fail++; $display("FAIL unknown_wdata_hold: got %h expected %h", bus.reg_wdata, exp_wdata);
    end
  endtask

  task automatic test_abort;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed;
    f = {8'h02, 24'h00_5555, 32'h1111_2222};
    do_frame(f, 40, 8, dw, dr, dd);
    model_frame(f, 40, ew, er, ed);
    n_checks++;
    if (dw !== 0) begin n_fail++; $display("FAIL abort_we: got %0d expected 0", dw); end
    n_checks++;
    if (dd !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", dd); end
    n_checks++;
    if (bus.err_cnt !== 8'(exp_err)) begin
      n_fail++; $display("FAIL abort_err_cnt: got %0d expected %0d", bus.err_cnt, exp_err);
    end
    n_checks++;
    if (bus.reg_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL abort_wdata_hold: got %h expected deadbeef", bus.reg_wdata);
    end
    f = {8'h02, 24'h00_ABCD, 32'h1234_5678};
    do_frame(f, 64, 8, dw, dr, dd);
    model_frame(f, 64, ew, er, ed);
    n_checks++;
    if (dw !== 1 || mon_wdata !== 32'h12345678 || mon_waddr !== 24'h00ABCD) begin
      n_fail++; $display("FAIL abort_recover: got we=%0d wdata=%h addr=%h expected 1/12345678/00abcd",
                         dw, mon_wdata, mon_waddr);
    end
  endtask

  task automatic test_extra_clocks;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed;
    f = {8'h02, 24'h00_0042, 32'h8765_4321};
    do_frame(f, 70, 6, dw, dr, dd);
    model_frame(f, 70, ew, er, ed);
    n_checks++;
    if (dw !== 1) begin n_fail++; $display("FAIL extra_we_count: got %0d expected 1", dw); end
    n_checks++;
    if (dd !== 1) begin n_fail++; $display("FAIL extra_done_count: got %0d expected 1", dd); end
    n_checks++;
    if (bus.reg_wdata !== 32'h87654321) begin
      n_fail++; $display("FAIL extra_wdata: got %h expected 87654321", bus.reg_wdata);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] f;
    int dw, dr, dd, ew, er, ed, w0, r0, d0;
    f = {8'h02, 24'h0A_BCDE, 32'h0BAD_F00D};
    miso_cap = 64'h0;
    bus.spi_cs = 1'b0;
    wait_clk(8);
    send_bits(f, 0, 20, 8);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    exp_addr = 24'h0; exp_wdata = 32'h0; exp_err = 0;
    n_checks++;
    if (bus.reg_addr !== 24'h0 || bus.reg_wdata !== 32'h0) begin
      n_fail++; $display("FAIL midreset_regs: got addr=%h wdata=%h expected 0/0", bus.reg_addr, bus.reg_wdata);
    end
    n_checks++;
    if ({bus.spi_miso, bus.reg_we, bus.reg_re, bus.frame_done} !== 4'b0000 || bus.err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs: got %b err=%h expected 0000 err=00",
                         {bus.spi_miso, bus.reg_we, bus.reg_re, bus.frame_done}, bus.err_cnt);
    end
    w0 = we_cnt; r0 = re_cnt; d0 = done_cnt;
    send_bits(f, 20, 44, 8);
    bus.spi_cs = 1'b1;
    wait_clk(24);
    n_checks++;
    if ((we_cnt - w0) + (re_cnt - r0) + (done_cnt - d0) !== 0) begin
      n_fail++; $display("FAIL midreset_ignored: got %0d strobes expected 0",
                         (we_cnt - w0) + (re_cnt - r0) + (done_cnt - d0));
    end
    n_checks++;
    if (bus.reg_addr !== 24'h0 || bus.err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL midreset_tail: got addr=%h err=%h expected 0/00", bus.reg_addr, bus.err_cnt);
    end
    f = {8'h02, 24'h00_0777, 32'h1357_9BDF};
    do_frame(f, 64, 8, dw, dr, dd);
    model_frame(f, 64, ew, er, ed);
    n_checks++;
    if (dw !== 1 || dd !== 1) begin
      n_fail++; $display("FAIL midreset_next_frame: got we=%0d done=%0d expected 1/1", dw, dd);
    end
    n_checks++;
    if (bus.reg_wdata !== 32'h13579BDF || bus.reg_addr !== 24'h000777) begin
      n_fail++; $display("FAIL midreset_next_data: got %h@%h expected 13579bdf@000777",
                         bus.reg_wdata, bus.reg_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] f;
    logic [7:0]  c;
    int nbits, half, dw, dr, dd, ew, er, ed;
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0, 3:    c = 8'h02;
        1:       c = 8'h03;
        default: c = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0, 1:    nbits = 64;
        2:       nbits = 70;
        default: nbits = $urandom_range(1, 63);
      endcase
      half   = $urandom_range(6, 9);
      rd_val = $urandom;
      f = {c, 24'($urandom), 32'($urandom)};
      do_frame(f, nbits, half, dw, dr, dd);
      model_frame(f, nbits, ew, er, ed);
      n_checks++;
      if (dw !== ew || dr !== er || dd !== ed) begin
        n_fail++; $display("FAIL b2b_strobes[%0d]: got we/re/done=%0d/%0d/%0d expected %0d/%0d/%0d (cmd=%h bits=%0d)",
                           k, dw, dr, dd, ew, er, ed, c, nbits);
      end
      n_checks++;
      if (bus.reg_addr !== exp_addr) begin
        n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, bus.reg_addr, exp_addr);
      end
      n_checks++;
      if (bus.reg_wdata !== exp_wdata) begin
        n_fail++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", k, bus.reg_wdata, exp_wdata);
      end
      n_checks++;
      if (bus.err_cnt !== 8'(exp_err)) begin
        n_fail++; $display("FAIL b2b_err[%0d]: got %0d expected %0d", k, bus.err_cnt, exp_err);
      end
      if (nbits >= 64) begin
        n_checks++;
        if (miso_cap !== ((c == 8'h03) ? {32'h0, rd_val} : 64'h0)) begin
          n_fail++; $display("FAIL b2b_miso[%0d]: got %h expected %h", k, miso_cap,
                             (c == 8'h03) ? {32'h0, rd_val} : 64'h0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.spi_cs = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    rd_val = 32'h0;
    miso_cap = 64'h0;
    test_reset();
    test_write();
    test_read();
    test_unknown_cmd();
    test_abort();
    test_extra_clocks();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
